// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART-fed ALU command sequencer:
// opcode values understood by the ALU, FSM state encoding and a
// small helper that tells whether an opcode is one the ALU implements.
package alu_uart_pkg;

  // Width of the opcode field the ALU decodes
  localparam int NB_OP_CODE = 6;

  // ALU function codes (low bits of the opcode byte)
  localparam logic [NB_OP_CODE-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_CODE-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_CODE-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_CODE-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_CODE-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_CODE-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP_CODE-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_CODE-1:0] OP_SRL = 6'b000010;

  // Sequencer state encoding
  localparam int NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // True when the opcode field names an operation the ALU implements
  function automatic logic op_is_valid(input logic [NB_OP_CODE-1:0] op);
    logic valid;
    valid = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: valid = 1'b1;
      default:                        valid = 1'b0;
    endcase
    return valid;
  endfunction

endpackage

// File: rtl/alu_uart_ctrl_edge_rise.sv
// Rising-edge detector for a level handshake signal. The previous value
// is registered with a configurable reset value so that a level that is
// already high when reset releases does not look like a new edge.
module edge_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_signal,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's level of the watched signal
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_prev <= RESET_VAL;
    end else begin
      r_prev <= i_signal;
    end
  end

  // Edge is reported in the first cycle the level is seen high
  assign o_rise = i_signal & ~r_prev;

endmodule

// File: rtl/alu_uart_ctrl.sv
// Command sequencer between a UART receiver and transmitter. Collects
// operand A, operand B and an opcode byte, drives them to an external
// combinational ALU, captures the result and requests its transmission.
// An inter-byte timeout abandons partial commands so the link recovers.
module alu_uart_ctrl
  import alu_uart_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_opcode,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_error,
  output logic               o_drop
);

  // Last count value before the timeout fires
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  logic [NB_TIMEOUT-1:0] r_timeout;
  logic [NB_DATA-1:0]    r_data_a;
  logic [NB_DATA-1:0]    r_data_b;
  logic [NB_OP-1:0]      r_opcode;
  logic [NB_DATA-1:0]    r_tx_data;
  logic                  r_tx_start;
  logic                  r_error;
  logic                  r_drop;

  logic                  w_rx_rise;
  logic                  w_tx_rise;
  logic                  w_collecting;
  logic                  w_timeout_hit;
  logic [NB_OP-1:0]      w_op_field;
  logic                  w_op_upper_zero;
  logic                  w_op_valid;

  // Byte-ready edge: the receiver may hold its done level for many clocks
  edge_rise #(
    .RESET_VAL(1'b1)
  ) u_rx_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_signal(i_rx_done),
    .o_rise  (w_rx_rise)
  );

  // Frame-finished edge from the transmitter
  edge_rise #(
    .RESET_VAL(1'b1)
  ) u_tx_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_signal(i_tx_done),
    .o_rise  (w_tx_rise)
  );

  // Only the operand-B and opcode waits are bounded in time
  assign w_collecting  = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_timeout_hit = w_collecting && (r_timeout == TIMEOUT_LAST);

  // Opcode byte is accepted only with clear upper bits and a known function
  assign w_op_field      = i_rx_data[NB_OP-1:0];
  assign w_op_upper_zero = (i_rx_data[NB_DATA-1:NB_OP] == '0);
  assign w_op_valid      = w_op_upper_zero && op_is_valid(NB_OP_CODE'(w_op_field));

  // Inter-byte timer: restarts on every byte and whenever no command is open
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timeout <= '0;
    end else if (w_rx_rise || !w_collecting || w_timeout_hit) begin
      r_timeout <= '0;
    end else begin
      r_timeout <= r_timeout + 1'b1;
    end
  end

  // Command sequencer; every output is a register, pulses default low
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_WAIT_A;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_opcode   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_error    <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_error    <= 1'b0;
      r_drop     <= 1'b0;

      case (r_state)
        ST_WAIT_A: begin
          if (w_rx_rise) begin
            r_data_a <= i_rx_data;
            r_state  <= ST_WAIT_B;
          end
        end

        ST_WAIT_B: begin
          // A byte arriving on the timeout cycle still counts
          if (w_rx_rise) begin
            r_data_b <= i_rx_data;
            r_state  <= ST_WAIT_OP;
          end else if (w_timeout_hit) begin
            r_error <= 1'b1;
            r_state <= ST_WAIT_A;
          end
        end

        ST_WAIT_OP: begin
          if (w_rx_rise) begin
            if (w_op_valid) begin
              r_opcode <= w_op_field;
              r_state  <= ST_EXEC;
            end else begin
              // Bad opcode: previous opcode stays on the ALU
              r_error <= 1'b1;
              r_state <= ST_WAIT_A;
            end
          end else if (w_timeout_hit) begin
            r_error <= 1'b1;
            r_state <= ST_WAIT_A;
          end
        end

        ST_EXEC: begin
          // ALU has seen the new opcode for a full cycle; capture its result
          r_tx_data <= i_alu_result;
          r_drop    <= w_rx_rise;
          r_state   <= ST_SEND;
        end

        ST_SEND: begin
          r_tx_start <= 1'b1;
          r_drop     <= w_rx_rise;
          r_state    <= ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          r_drop <= w_rx_rise;
          if (w_tx_rise) begin
            r_state <= ST_WAIT_A;
          end
        end

        default: begin
          r_state <= ST_WAIT_A;
        end
      endcase
    end
  end

  assign o_data_a   = r_data_a;
  assign o_data_b   = r_data_b;
  assign o_opcode   = r_opcode;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_error    = r_error;
  assign o_drop     = r_drop;

endmodule

// File: doc/alu_uart_ctrl.md
# alu_uart_ctrl

Command sequencer that sits directly downstream of the UART receiver and upstream of the UART transmitter. It collects three received bytes (operand A, operand B, opcode), presents them to the combinational ALU, registers the result and hands it to the transmitter with a one-cycle start strobe. It enforces an inter-byte timeout so a partial command never wedges the link.

## Interface
Parameters:
- NB_DATA, 8, width of operands, result and UART bytes
- NB_OP, 6, opcode width (low bits of the opcode byte)
- TIMEOUT_CYCLES, 1000000, clocks allowed between bytes of one command
- NB_TIMEOUT, 20, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_DATA  receiver parallel byte
- i_rx_done  in  1  receiver byte-ready level; may stay high for many clocks
- i_alu_result  in  NB_DATA  combinational ALU output
- i_tx_done  in  1  transmitter frame-finished level
- o_data_a  out  NB_DATA  operand A to ALU
- o_data_b  out  NB_DATA  operand B to ALU
- o_opcode  out  NB_OP  opcode to ALU
- o_tx_data  out  NB_DATA  byte to transmitter
- o_tx_start  out  1  one-cycle transmit request
- o_error  out  1  one-cycle pulse: invalid opcode or timeout
- o_drop  out  1  one-cycle pulse: byte received while busy

## Operation
- Byte event = rising edge of i_rx_done (registered previous value, reset to 1 so a high level at reset release is not an event). Tx-done event = rising edge of i_tx_done, same rule.
- States: ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP, ST_EXEC, ST_SEND, ST_WAIT_TX.
- ST_WAIT_A: on byte event, o_data_a <= i_rx_data, go ST_WAIT_B.
- ST_WAIT_B: on byte event, o_data_b <= i_rx_data, go ST_WAIT_OP.
- ST_WAIT_OP: on byte event, check byte. Valid: upper NB_DATA-NB_OP bits zero and low bits in {ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010}. If valid, o_opcode <= low bits, go ST_EXEC. Otherwise pulse o_error, keep o_opcode, go ST_WAIT_A.
- ST_EXEC: o_tx_data <= i_alu_result, go ST_SEND.
- ST_SEND: o_tx_start = 1 for exactly this cycle, go ST_WAIT_TX.
- ST_WAIT_TX: on tx-done event, go ST_WAIT_A.
- Timeout: counter cleared on every byte event and in ST_WAIT_A; increments in ST_WAIT_B/ST_WAIT_OP. On reaching TIMEOUT_CYCLES-1, pulse o_error and go ST_WAIT_A; captured operands are retained.
- A byte event in ST_EXEC/ST_SEND/ST_WAIT_TX pulses o_drop; the byte is discarded.
- Operand registers hold their values until overwritten, so the ALU output stays stable during transmission.

## Timing
- Reset: all outputs 0, state ST_WAIT_A, timeout counter 0, edge registers 1.
- Opcode byte event at clock edge k (rx_done seen low at k-1, high at k): state ST_EXEC from k+1, o_tx_data valid after k+2, o_tx_start high during cycle k+2..k+3. Latency from opcode edge to start strobe: 2 clocks.
- o_error and o_drop are combinational-free registered pulses, exactly one clock wide.
- Timeout and a byte event in the same cycle: the byte wins; counter clears, no error.
- A tx-done event in any state except ST_WAIT_TX is ignored.
- Reset mid-command: returns to ST_WAIT_A in the next cycle; an in-flight o_tx_start is deasserted.

## Structure
- Package alu_uart_pkg: opcode localparams, state encodings, NB_STATE.
- Sub-module edge_rise (registered previous value, parameterised reset value, outputs rise pulse): instantiated for i_rx_done and i_tx_done.
- Timeout counter and FSM in the top module.

## Test plan
- Bytes 0x05, 0x03, 0x20 (ADD), ALU model returns 0x08 -> o_tx_start one pulse 2 clocks after third edge, o_tx_data=0x08. Then i_tx_done rises -> back to ST_WAIT_A.
- Bytes 0x0F, 0x01, 0x3F (invalid) -> o_error single pulse, no o_tx_start, next triple 0x80,0x01,0x03 (SRA) -> o_tx_data=0xC0.
- i_rx_done held high 200 clocks per byte -> exactly one capture per byte.
- Bytes 0x11, 0x22, then silence for TIMEOUT_CYCLES (bench parameter 16) -> o_error pulse, next byte 0x33 lands in o_data_a.
- Extra byte during ST_WAIT_TX -> o_drop pulse, o_data_a unchanged. Reset asserted in ST_WAIT_OP -> all outputs 0 the next cycle.
